// File: rtl/slot_sequencer.sv
// slot_sequencer: steps through the enabled virtual channels of one ADC
// acquisition cycle. A cycle runs SYNC, then one SLOT + RUN pair for each
// enabled vchn in ascending order, then DONE. Every output is a flop that
// is decoded from the next state, so each output changes on the same edge
// as the state it describes.
module slot_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [3:0]  i_vchn_en,
    input  logic [15:0] i_slot_len,
    input  logic [31:0] i_data_len,
    input  logic [31:0] i_adc_delay,
    input  logic        i_clr_overrun,
    output logic        o_sync,
    output logic        o_slot_sync,
    output logic [1:0]  o_wr_vchn,
    output logic [7:0]  o_data_len,
    output logic [7:0]  o_adc_delay,
    output logic [3:0]  o_ch_mask,
    output logic        o_complite,
    output logic        o_busy,
    output logic        o_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SLOT = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Returns {found, index} for the lowest enabled vchn whose number is at
    // least 'from'. A 'from' value of 4 never matches, so the caller can
    // pass "current + 1" without a special case for the last vchn.
    function automatic logic [2:0] find_next(input logic [3:0] en, input logic [2:0] from);
        logic       hit;
        logic [1:0] idx;
        hit = 1'b0;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!hit && (3'(i) >= from) && en[i]) begin
                hit = 1'b1;
                idx = 2'(i);
            end else begin
                hit = hit;
            end
        end
        return {hit, idx};
    endfunction

    state_t      state_r, state_s;
    logic [15:0] cnt_r, cnt_s;
    logic [3:0]  sh_en_r;
    logic [15:0] sh_len_r;
    logic [31:0] sh_dlen_r;
    logic [31:0] sh_adc_r;
    logic        load_s;
    logic        enter_slot_s;
    logic [1:0]  vchn_s;
    logic [2:0]  nxt_s;

    logic        sync_r, slot_sync_r, complite_r, busy_r, overrun_r;
    logic [1:0]  wr_vchn_r;
    logic [7:0]  data_len_r, adc_delay_r;
    logic [3:0]  ch_mask_r;

    logic        sync_s, slot_sync_s, complite_s, busy_s;
    logic [7:0]  data_len_s, adc_delay_s;
    logic [3:0]  ch_mask_s;

    // Next-state logic, RUN down-counter and selection of the next active vchn.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        vchn_s       = wr_vchn_r;
        enter_slot_s = 1'b0;
        nxt_s        = 3'b000;
        load_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // Abort wins over a simultaneous start.
                if (i_start && !i_abort) begin
                    state_s = ST_SYNC;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SYNC: begin
                nxt_s = find_next(sh_en_r, 3'd0);
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else if (nxt_s[2]) begin
                    state_s      = ST_SLOT;
                    vchn_s       = nxt_s[1:0];
                    enter_slot_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_SLOT: begin
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else begin
                    // A slot length of zero still gives one RUN cycle.
                    state_s = ST_RUN;
                    cnt_s   = (sh_len_r == 16'd0) ? 16'd0 : (sh_len_r - 16'd1);
                end
            end
            ST_RUN: begin
                nxt_s = find_next(sh_en_r, {1'b0, wr_vchn_r} + 3'd1);
                if (i_abort) begin
                    state_s = ST_IDLE;
                end else if (cnt_r != 16'd0) begin
                    cnt_s = cnt_r - 16'd1;
                end else if (nxt_s[2]) begin
                    state_s      = ST_SLOT;
                    vchn_s       = nxt_s[1:0];
                    enter_slot_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state; vchn fields change only on entry to a SLOT.
    always_comb begin
        sync_s      = (state_s == ST_SYNC);
        slot_sync_s = (state_s == ST_SLOT);
        complite_s  = (state_s == ST_DONE);
        busy_s      = (state_s != ST_IDLE);
        if ((state_s == ST_SLOT) || (state_s == ST_RUN)) begin
            ch_mask_s = 4'b0001 << vchn_s;
        end else begin
            ch_mask_s = 4'b0000;
        end
        if (enter_slot_s) begin
            data_len_s  = sh_dlen_r[{vchn_s, 3'b000} +: 8];
            adc_delay_s = sh_adc_r[{vchn_s, 3'b000} +: 8];
        end else begin
            data_len_s  = data_len_r;
            adc_delay_s = adc_delay_r;
        end
    end

    // State, counter and shadow copies of the configuration taken at cycle start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            sh_en_r   <= 4'd0;
            sh_len_r  <= 16'd0;
            sh_dlen_r <= 32'd0;
            sh_adc_r  <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (load_s) begin
                sh_en_r   <= i_vchn_en;
                sh_len_r  <= i_slot_len;
                sh_dlen_r <= i_data_len;
                sh_adc_r  <= i_adc_delay;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= 1'b0;
            slot_sync_r <= 1'b0;
            complite_r  <= 1'b0;
            busy_r      <= 1'b0;
            ch_mask_r   <= 4'd0;
            wr_vchn_r   <= 2'd0;
            data_len_r  <= 8'd0;
            adc_delay_r <= 8'd0;
        end else begin
            sync_r      <= sync_s;
            slot_sync_r <= slot_sync_s;
            complite_r  <= complite_s;
            busy_r      <= busy_s;
            ch_mask_r   <= ch_mask_s;
            wr_vchn_r   <= vchn_s;
            data_len_r  <= data_len_s;
            adc_delay_r <= adc_delay_s;
        end
    end

    // Sticky overrun flag: a start seen while busy sets it, and setting beats clearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (i_start && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else if (i_clr_overrun) begin
            overrun_r <= 1'b0;
        end
    end

    assign o_sync      = sync_r;
    assign o_slot_sync = slot_sync_r;
    assign o_complite  = complite_r;
    assign o_busy      = busy_r;
    assign o_ch_mask   = ch_mask_r;
    assign o_wr_vchn   = wr_vchn_r;
    assign o_data_len  = data_len_r;
    assign o_adc_delay = adc_delay_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_slot_sequencer.sv
// Directed testbench for slot_sequencer. Cycle c is the clock period that
// follows edge c-1, where edge 0 is the edge that samples i_start. Outputs
// are sampled 1 time unit after each rising edge.
module tb_slot_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start, i_abort, i_clr_overrun;
    logic [3:0]  i_vchn_en;
    logic [15:0] i_slot_len;
    logic [31:0] i_data_len, i_adc_delay;
    logic        o_sync, o_slot_sync, o_complite, o_busy, o_overrun;
    logic [1:0]  o_wr_vchn;
    logic [7:0]  o_data_len, o_adc_delay;
    logic [3:0]  o_ch_mask;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    slot_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_vchn_en(i_vchn_en), .i_slot_len(i_slot_len), .i_data_len(i_data_len),
        .i_adc_delay(i_adc_delay), .i_clr_overrun(i_clr_overrun),
        .o_sync(o_sync), .o_slot_sync(o_slot_sync), .o_wr_vchn(o_wr_vchn),
        .o_data_len(o_data_len), .o_adc_delay(o_adc_delay), .o_ch_mask(o_ch_mask),
        .o_complite(o_complite), .o_busy(o_busy), .o_overrun(o_overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulses i_start across edge 0; returns during cycle 1.
    task automatic launch();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic chk_cyc(input int c, input logic e_sync, input logic e_slot,
                           input logic e_comp, input logic e_busy, input logic [3:0] e_mask);
        check($sformatf("c%0d sync", c),      32'(o_sync),      32'(e_sync));
        check($sformatf("c%0d slot_sync", c), 32'(o_slot_sync), 32'(e_slot));
        check($sformatf("c%0d complite", c),  32'(o_complite),  32'(e_comp));
        check($sformatf("c%0d busy", c),      32'(o_busy),      32'(e_busy));
        check($sformatf("c%0d ch_mask", c),   32'(o_ch_mask),   32'(e_mask));
    endtask

    // Expected behaviour for en=4'hF, L=3, data_len=44_33_22_11, adc=0D_0C_0B_0A:
    // slots at 2/6/10/14, complite at 18, vchn fields held afterwards.
    task automatic chk_std(input int c);
        int         k;
        logic [3:0] m;
        logic [7:0] dl, ad;
        k  = (c >= 18) ? 3 : ((c >= 2) ? (c - 2) / 4 : 0);
        m  = (c >= 2 && c <= 17) ? (4'b0001 << k) : 4'b0000;
        dl = 8'(8'h11 * (k + 1));
        ad = 8'(8'h0A + k);
        chk_cyc(c, c == 1, (c >= 2 && c <= 14 && (c - 2) % 4 == 0), c == 18, c <= 18, m);
        if (c >= 2) begin
            check($sformatf("c%0d wr_vchn", c),   32'(o_wr_vchn),   32'(k));
            check($sformatf("c%0d data_len", c),  32'(o_data_len),  32'(dl));
            check($sformatf("c%0d adc_delay", c), 32'(o_adc_delay), 32'(ad));
        end
    endtask

    task automatic set_std();
        i_vchn_en   = 4'hF;
        i_slot_len  = 16'd3;
        i_data_len  = 32'h44_33_22_11;
        i_adc_delay = 32'h0D_0C_0B_0A;
    endtask

    // Standard four-slot cycle; with inj set, a repeated start is injected in
    // cycle 5 and a start+clear pair in cycle 8.
    task automatic std_run(input bit inj);
        set_std();
        launch();
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) step();
            i_start = 1'b0;
            i_clr_overrun = 1'b0;
            chk_std(c);
            check($sformatf("c%0d overrun", c), 32'(o_overrun), 32'(inj && c >= 6));
            if (inj && c == 5) i_start = 1'b1;
            if (inj && c == 8) begin
                i_start = 1'b1;
                i_clr_overrun = 1'b1;
            end
        end
        if (inj) begin
            i_clr_overrun = 1'b1;
            step();
            i_clr_overrun = 1'b0;
            check("clr overrun", 32'(o_overrun), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_clr_overrun = 1'b0;
        i_vchn_en = 4'h0; i_slot_len = 16'd0; i_data_len = 32'd0; i_adc_delay = 32'd0;
        #12;
        chk_cyc(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("rst overrun", 32'(o_overrun), 32'd0);
        check("rst wr_vchn", 32'(o_wr_vchn), 32'd0);
        check("rst data_len", 32'(o_data_len), 32'd0);
        check("rst adc_delay", 32'(o_adc_delay), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();
        check("idle after rst busy", 32'(o_busy), 32'd0);
        check("idle after rst sync", 32'(o_sync), 32'd0);

        // All four vchns, L=3.
        std_run(1'b0);

        // en=1010, L=0: slots at 2 (vchn1) and 4 (vchn3), complite at 6.
        i_vchn_en = 4'b1010; i_slot_len = 16'd0;
        i_data_len = 32'h40_30_20_10; i_adc_delay = 32'h04_03_02_01;
        launch();
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) step();
            chk_cyc(c, c == 1, (c == 2 || c == 4), c == 6, c <= 6,
                    (c == 2 || c == 3) ? 4'b0010 : ((c == 4 || c == 5) ? 4'b1000 : 4'b0000));
            if (c >= 2) begin
                check($sformatf("b c%0d wr_vchn", c), 32'(o_wr_vchn), (c <= 3) ? 32'd1 : 32'd3);
                check($sformatf("b c%0d data_len", c), 32'(o_data_len), (c <= 3) ? 32'h20 : 32'h40);
                check($sformatf("b c%0d adc_delay", c), 32'(o_adc_delay), (c <= 3) ? 32'h02 : 32'h04);
            end
        end

        // No vchn enabled: sync at 1, complite at 2, mask stays 0, fields held.
        i_vchn_en = 4'b0000;
        launch();
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) step();
            chk_cyc(c, c == 1, 1'b0, c == 2, c <= 2, 4'd0);
            check($sformatf("e0 c%0d wr_vchn", c), 32'(o_wr_vchn), 32'd3);
        end

        // Repeated start while busy: overrun set, timing unchanged, then cleared.
        std_run(1'b1);

        // Abort (together with start) during RUN of vchn2, cycle 11.
        set_std();
        launch();
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) step();
            i_abort = 1'b0;
            i_start = 1'b0;
            if (c <= 11) chk_std(c);
            else chk_cyc(c, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            check($sformatf("ab c%0d overrun", c), 32'(o_overrun), 32'(c >= 12));
            if (c == 11) begin
                i_abort = 1'b1;
                i_start = 1'b1;
            end
        end
        i_clr_overrun = 1'b1;
        step();
        i_clr_overrun = 1'b0;
        check("ab clr overrun", 32'(o_overrun), 32'd0);

        // Abort and start together in IDLE: nothing starts, no overrun.
        i_abort = 1'b1; i_start = 1'b1;
        step();
        i_abort = 1'b0; i_start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c > 1) step();
            chk_cyc(c, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            check($sformatf("ia c%0d overrun", c), 32'(o_overrun), 32'd0);
        end

        // Configuration changed in cycle 3 only affects the next cycle.
        set_std();
        launch();
        for (int c = 1; c <= 19; c++) begin
            if (c > 1) step();
            chk_std(c);
            if (c == 3) begin
                i_slot_len = 16'd1;
                i_vchn_en  = 4'b0001;
            end
        end
        launch();
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) step();
            chk_cyc(c, c == 1, c == 2, c == 4, c <= 4, (c == 2 || c == 3) ? 4'b0001 : 4'b0000);
        end

        // Reset asserted mid-cycle drops mask and busy at once, no complite.
        set_std();
        launch();
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_cyc(100, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("mid rst wr_vchn", 32'(o_wr_vchn), 32'd0);
        repeat (2) step();
        chk_cyc(101, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_cyc(102 + c, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
